round_key_bank: RTL and testbench
=================================

# round_key_bank

Multi-slot round-key store and streamer between `kuznechik_keygen` and `kuznechik_encrypt`. Captures round-key pairs from the key generator into one of `SLOTS` independent banks, marks a bank valid once all `NUM_KEYS` keys are in, then streams any valid bank to the cipher core one key per beat. Keys stream over a valid/ready handshake, in forward order for encryption or reverse order for decryption. It replaces the ad-hoc two-phase pair shifter in the top level and lets a master-key switch be served from a stored bank without regenerating keys.

## Interface
Parameters:
- `KEY_W`, 128: width of one round key.
- `NUM_KEYS`, 10: round keys per bank; must be even and ≥ 2.
- `SLOTS`, 2: number of banks, ≥ 1; `SLOT_W` = max(1, clog2(SLOTS)).

Ports:
- `clk`  in  1: single clock; all logic on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `wr_start`  in  1: pulse; clears slot `wr_slot`, invalidates it and rewinds its write pointer.
- `wr_slot`  in  SLOT_W: target slot; sampled on `wr_start` and on every `pair_valid`.
- `pair_valid`  in  1: one key pair present on `pair_data`.
- `pair_data`  in  2*KEY_W: `[2*KEY_W-1:KEY_W]` is key 2i; `[KEY_W-1:0]` is key 2i+1.
- `slot_valid`  out  SLOTS: bit s is 1 when slot s holds all `NUM_KEYS` keys.
- `wr_err`  out  1: one-cycle pulse when a write is rejected.
- `rd_start`  in  1: pulse; requests a stream of slot `rd_slot`.
- `rd_slot`  in  SLOT_W: slot to stream.
- `rd_dir`  in  1: 0 streams keys 0..NUM_KEYS-1 (encrypt); 1 streams NUM_KEYS-1..0 (decrypt).
- `rd_err`  out  1: one-cycle pulse when `rd_start` is rejected.
- `key_out`  out  KEY_W: current round key (registered).
- `key_valid`  out  1: `key_out` is valid.
- `key_last`  out  1: the current beat is the final key of the stream.
- `key_ready`  in  1: consumer accepts the beat when `key_valid && key_ready`.
- `busy`  out  1: a stream is in progress.

## Operation
- Storage: a SLOTS×NUM_KEYS×KEY_W register array, plus one write pointer per slot (0..NUM_KEYS/2) and one valid bit per slot.
- Write path:
  - `wr_start` sets the slot pointer to 0 and clears `slot_valid[wr_slot]`. Stored key data is not cleared.
  - `pair_valid` writes key 2p and key 2p+1 of slot `wr_slot`, where p is that slot's pointer, then increments the pointer.
  - When the pointer reaches NUM_KEYS/2, `slot_valid` sets on the cycle after the final pair.
- Write rejections. Each of the following is ignored and raises `wr_err`:
  - `pair_valid` to a full slot (pointer = NUM_KEYS/2);
  - `wr_start` or `pair_valid` targeting the slot currently being streamed;
  - `wr_slot` ≥ SLOTS.
- Read FSM:
  - IDLE: on `rd_start`:
    - If the slot is valid and < SLOTS, latch the slot and direction, set the index to 0 or NUM_KEYS-1, and go to STREAM.
    - Otherwise pulse `rd_err` and stay in IDLE.
  - STREAM: `key_valid` = 1 and `key_out` = mem[slot][idx]. On a handshake, step idx by +1 (dir 0) or −1 (dir 1).
  - `key_last` = 1 when idx = NUM_KEYS-1 (dir 0) or 0 (dir 1).
  - A handshake on the last beat returns to IDLE.
  - `rd_start` in STREAM is ignored, with no error.
- Simultaneous events:
  - `wr_start` together with `pair_valid` on the same slot: `wr_start` wins and the pair is dropped.
  - A write to slot A while slot B streams proceeds normally.
  - `rd_start` for a slot in the same cycle its final pair arrives is rejected, because `slot_valid` is not yet set.
- Reset mid-operation: FSM to IDLE, every pointer to 0, every `slot_valid` to 0. Any stream in progress is abandoned.

## Timing
- Reset values: `slot_valid`=0, `wr_err`=0, `rd_err`=0, `key_out`=0, `key_valid`=0, `key_last`=0, `busy`=0.
- `rd_start` accepted at edge N: `key_valid`, `busy` and the first key are visible from N+1.
- With `key_ready` held at 1, one key per cycle; a full stream occupies NUM_KEYS cycles, N+1..N+NUM_KEYS.
- `busy` and `key_valid` drop on the edge that accepts the last beat. The next `rd_start` is accepted on the following cycle, so there is a one-cycle gap between streams.
- Backpressure: `key_out`, `key_valid` and `key_last` hold steady while `key_ready`=0.
- `wr_err` and `rd_err` are registered and pulse exactly one cycle after the offending request.
- `slot_valid` rises one cycle after the final `pair_valid`.

## Test plan
- Load slot 0 with 5 pairs whose keys are 128'h0..128'h9 (key k = k), then `rd_start` with dir=0 and `key_ready`=1:
  - expect `slot_valid`=2'b01;
  - expect keys 0,1,…,9 on consecutive cycles, with `key_last` only on key 9.
- Same load, dir=1: expect keys 9..0, with `key_last` on key 0.
- Stream slot 0 while toggling `key_ready` 1,0,0,1,…: every key appears exactly once, in order, and `key_out` is held while stalled.
- `rd_start` on empty slot 1 → `rd_err` pulse, `busy`=0. A 6th `pair_valid` to full slot 0 → `wr_err`, and the stored data is unchanged.
- While slot 0 streams:
  - `wr_start` to slot 0 → `wr_err`, and the stream continues intact;
  - loading slot 1 in parallel succeeds, giving `slot_valid`=2'b11.
- Assert `rst` mid-stream at beat 4: the next cycle shows `key_valid`=0, `busy`=0 and `slot_valid`=0. A subsequent `rd_start` → `rd_err`.

Source files
------------

// File: rtl/round_key_bank.sv
// round_key_bank: multi-slot round-key store between the key generator and
// the cipher core. Key pairs are captured into independent banks; a complete
// bank can be streamed out one key per beat, forward (encrypt) or reverse
// (decrypt), over a valid/ready handshake.
module round_key_bank #(
  parameter  int KEY_W    = 128,
  parameter  int NUM_KEYS = 10,
  parameter  int SLOTS    = 2,
  localparam int SLOT_W   = (SLOTS > 1) ? $clog2(SLOTS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_start,
  input  logic [SLOT_W-1:0]    wr_slot,
  input  logic                 pair_valid,
  input  logic [2*KEY_W-1:0]   pair_data,
  output logic [SLOTS-1:0]     slot_valid,
  output logic                 wr_err,
  input  logic                 rd_start,
  input  logic [SLOT_W-1:0]    rd_slot,
  input  logic                 rd_dir,
  output logic                 rd_err,
  output logic [KEY_W-1:0]     key_out,
  output logic                 key_valid,
  output logic                 key_last,
  input  logic                 key_ready,
  output logic                 busy
);

  localparam int HALF  = NUM_KEYS / 2;
  localparam int PTR_W = $clog2(HALF + 1);
  localparam int IDX_W = $clog2(NUM_KEYS);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_KEYS - 1);
  localparam logic [IDX_W-1:0] IDX_ZERO = '0;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_STREAM = 1'b1;

  // Key storage; contents are never cleared, only the valid bits are.
  logic [KEY_W-1:0] mem [SLOTS][NUM_KEYS];

  logic [PTR_W-1:0] ptr_reg [SLOTS];
  logic [SLOTS-1:0] slot_valid_reg;
  logic             wr_err_reg;
  logic             rd_err_reg;

  logic [0:0]        state_reg;
  logic [SLOT_W-1:0] rd_slot_reg;
  logic              rd_dir_reg;
  logic [IDX_W-1:0]  idx_reg;
  logic [KEY_W-1:0]  key_out_reg;
  logic              key_last_reg;

  // Per-slot decode of the write and read requests.
  logic [SLOTS-1:0] wr_sel;
  logic [SLOTS-1:0] rd_sel;
  logic [SLOTS-1:0] locked;
  logic [SLOTS-1:0] full;
  logic [SLOTS-1:0] clr;
  logic [SLOTS-1:0] wen;
  logic [SLOTS-1:0] rej;

  logic             wr_in_range;
  logic             wr_err_next;
  logic             rd_ok;
  logic             streaming;
  logic             beat_accept;
  logic [IDX_W-1:0] idx_first;
  logic [IDX_W-1:0] idx_next;
  logic             next_is_last;

  assign streaming   = (state_reg == ST_STREAM);
  assign beat_accept = streaming && key_ready;

  genvar gi;
  generate
    for (gi = 0; gi < SLOTS; gi++) begin : g_slot
      assign wr_sel[gi] = (wr_slot == SLOT_W'(gi));
      assign rd_sel[gi] = (rd_slot == SLOT_W'(gi));
      // The slot feeding the cipher core must not change under it.
      assign locked[gi] = streaming && (rd_slot_reg == SLOT_W'(gi));
      assign full[gi]   = (ptr_reg[gi] == PTR_W'(HALF));
      // wr_start beats a simultaneous pair on the same slot.
      assign clr[gi]    = wr_start && wr_sel[gi] && !locked[gi];
      assign wen[gi]    = pair_valid && !wr_start && wr_sel[gi] && !locked[gi] && !full[gi];
      assign rej[gi]    = wr_sel[gi] &&
                          (((wr_start || pair_valid) && locked[gi]) ||
                           (pair_valid && !wr_start && full[gi]));
    end
  endgenerate

  // Out-of-range slot numbers match no decoder bit.
  assign wr_in_range = |wr_sel;
  assign wr_err_next = ((wr_start || pair_valid) && !wr_in_range) || (|rej);
  assign rd_ok       = |(rd_sel & slot_valid_reg);

  // Index arithmetic for the read side.
  always_comb begin
    idx_first    = rd_dir ? IDX_LAST : IDX_ZERO;
    idx_next     = rd_dir_reg ? (idx_reg - 1'b1) : (idx_reg + 1'b1);
    next_is_last = rd_dir_reg ? (idx_next == IDX_ZERO) : (idx_next == IDX_LAST);
  end

  // Key array write: each accepted pair lands at the slot's pointer position.
  always_ff @(posedge clk) begin
    for (int s = 0; s < SLOTS; s++) begin
      for (int p = 0; p < HALF; p++) begin
        if (wen[s] && (ptr_reg[s] == PTR_W'(p))) begin
          mem[s][2*p]   <= pair_data[2*KEY_W-1:KEY_W];
          mem[s][2*p+1] <= pair_data[KEY_W-1:0];
        end
      end
    end
  end

  // Write pointers, slot valid bits and the write error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SLOTS; s++) begin
        ptr_reg[s] <= '0;
      end
      slot_valid_reg <= '0;
      wr_err_reg     <= 1'b0;
    end else begin
      for (int s = 0; s < SLOTS; s++) begin
        if (clr[s]) begin
          ptr_reg[s]        <= '0;
          slot_valid_reg[s] <= 1'b0;
        end else if (wen[s]) begin
          ptr_reg[s] <= ptr_reg[s] + 1'b1;
          if (ptr_reg[s] == PTR_W'(HALF - 1)) begin
            slot_valid_reg[s] <= 1'b1;
          end
        end
      end
      wr_err_reg <= wr_err_next;
    end
  end

  // Read FSM: registered key output, advanced on each accepted beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      rd_slot_reg  <= '0;
      rd_dir_reg   <= 1'b0;
      idx_reg      <= '0;
      key_out_reg  <= '0;
      key_last_reg <= 1'b0;
      rd_err_reg   <= 1'b0;
    end else begin
      rd_err_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (rd_start) begin
            if (rd_ok) begin
              rd_slot_reg  <= rd_slot;
              rd_dir_reg   <= rd_dir;
              idx_reg      <= idx_first;
              key_out_reg  <= mem[rd_slot][idx_first];
              key_last_reg <= 1'b0;
              state_reg    <= ST_STREAM;
            end else begin
              rd_err_reg <= 1'b1;
            end
          end
        end
        default: begin
          if (beat_accept) begin
            if (key_last_reg) begin
              key_last_reg <= 1'b0;
              state_reg    <= ST_IDLE;
            end else begin
              idx_reg      <= idx_next;
              key_out_reg  <= mem[rd_slot_reg][idx_next];
              key_last_reg <= next_is_last;
            end
          end
        end
      endcase
    end
  end

  assign slot_valid = slot_valid_reg;
  assign wr_err     = wr_err_reg;
  assign rd_err     = rd_err_reg;
  assign key_out    = key_out_reg;
  assign key_valid  = streaming;
  assign key_last   = key_last_reg;
  assign busy       = streaming;

endmodule

// File: tb/tb_round_key_bank.sv
// Directed bench for round_key_bank: a key model feeds a scoreboard queue of
// expected beats, popped and compared on every observed handshake.
module tb_round_key_bank;

  localparam int KEY_W  = 128;
  localparam int NK     = 10;
  localparam int SLOTS  = 2;
  localparam int SLOT_W = 1;

  logic               clk = 1'b0;
  logic               rst;
  logic               wr_start;
  logic [SLOT_W-1:0]  wr_slot;
  logic               pair_valid;
  logic [2*KEY_W-1:0] pair_data;
  logic [SLOTS-1:0]   slot_valid;
  logic               wr_err;
  logic               rd_start;
  logic [SLOT_W-1:0]  rd_slot;
  logic               rd_dir;
  logic               rd_err;
  logic [KEY_W-1:0]   key_out;
  logic               key_valid;
  logic               key_last;
  logic               key_ready;
  logic               busy;

  round_key_bank #(.KEY_W(KEY_W), .NUM_KEYS(NK), .SLOTS(SLOTS)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_start   (wr_start),
    .wr_slot    (wr_slot),
    .pair_valid (pair_valid),
    .pair_data  (pair_data),
    .slot_valid (slot_valid),
    .wr_err     (wr_err),
    .rd_start   (rd_start),
    .rd_slot    (rd_slot),
    .rd_dir     (rd_dir),
    .rd_err     (rd_err),
    .key_out    (key_out),
    .key_valid  (key_valid),
    .key_last   (key_last),
    .key_ready  (key_ready),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [KEY_W-1:0] key;
    logic             last;
  } beat_t;

  beat_t            exp_q[$];
  logic [KEY_W-1:0] model [SLOTS][NK];
  int               n_tests = 0;
  int               n_fail  = 0;
  bit               held_flag = 1'b0;
  logic [KEY_W-1:0] held_val;
  int               ncyc;

  task automatic check(input string tag, input logic [KEY_W-1:0] obs, input logic [KEY_W-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("check %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle of consumer behaviour: scoreboard on handshake, hold check on stall.
  task automatic consume_cycle(input bit rdy);
    beat_t b;
    key_ready = rdy;
    if (held_flag) check("hold_key", key_out, held_val);
    held_flag = 1'b0;
    if (key_valid) begin
      if (rdy) begin
        if (exp_q.size() == 0) begin
          check("extra_beat", KEY_W'(exp_q.size()), 1);
        end else begin
          b = exp_q.pop_front();
          check("key", key_out, b.key);
          check("last", KEY_W'(key_last), KEY_W'(b.last));
        end
      end else begin
        held_flag = 1'b1;
        held_val  = key_out;
      end
    end
    tick();
  endtask

  // Issue rd_start; on acceptance queue the expected beats from the model.
  task automatic start_read(input int s, input bit dir, input bit ok);
    beat_t b;
    int k;
    rd_start = 1'b1;
    rd_slot  = SLOT_W'(s);
    rd_dir   = dir;
    if (ok) begin
      for (int j = 0; j < NK; j++) begin
        k      = dir ? (NK - 1 - j) : j;
        b.key  = model[s][k];
        b.last = (j == NK - 1);
        exp_q.push_back(b);
      end
    end
    tick();
    rd_start = 1'b0;
    check("rd_err", KEY_W'(rd_err), KEY_W'(!ok));
    check("busy_start", KEY_W'(busy), KEY_W'(ok));
    check("valid_start", KEY_W'(key_valid), KEY_W'(ok));
  endtask

  // Consume until the scoreboard is empty; mode 0 = always ready, 1 = 1,0,0 pattern.
  task automatic drain(input int mode, output int cycles);
    cycles = 0;
    while (exp_q.size() > 0 && cycles < 200) begin
      consume_cycle(mode == 0 ? 1'b1 : ((cycles % 3) == 0));
      cycles++;
    end
    check("drain_timeout", KEY_W'(exp_q.size()), 0);
    check("busy_end", KEY_W'(busy), 0);
    check("valid_end", KEY_W'(key_valid), 0);
  endtask

  task automatic load_slot(input int s, input int base);
    logic [KEY_W-1:0] ka;
    logic [KEY_W-1:0] kb;
    wr_start = 1'b1;
    wr_slot  = SLOT_W'(s);
    tick();
    wr_start = 1'b0;
    for (int p = 0; p < NK / 2; p++) begin
      ka = KEY_W'(base + 2 * p);
      kb = KEY_W'(base + 2 * p + 1);
      model[s][2*p]   = ka;
      model[s][2*p+1] = kb;
      pair_valid = 1'b1;
      pair_data  = {ka, kb};
      if (p == NK / 2 - 1) check("valid_before_last", KEY_W'(slot_valid[s]), 0);
      tick();
      check("wr_err_load", KEY_W'(wr_err), 0);
    end
    pair_valid = 1'b0;
    check("valid_after_last", KEY_W'(slot_valid[s]), 1);
  endtask

  initial begin
    logic [KEY_W-1:0] ka;
    logic [KEY_W-1:0] kb;

    rst = 1'b1; wr_start = 1'b0; wr_slot = '0; pair_valid = 1'b0; pair_data = '0;
    rd_start = 1'b0; rd_slot = '0; rd_dir = 1'b0; key_ready = 1'b0;
    tick(); tick();
    check("rst_slot_valid", KEY_W'(slot_valid), 0);
    check("rst_wr_err", KEY_W'(wr_err), 0);
    check("rst_rd_err", KEY_W'(rd_err), 0);
    check("rst_key_out", key_out, 0);
    check("rst_key_valid", KEY_W'(key_valid), 0);
    check("rst_key_last", KEY_W'(key_last), 0);
    check("rst_busy", KEY_W'(busy), 0);
    rst = 1'b0;
    tick();

    // Load slot 0 with key k = k.
    load_slot(0, 0);
    check("slot_valid_01", KEY_W'(slot_valid), 2'b01);

    // Read of empty slot 1 is rejected.
    start_read(1, 1'b0, 1'b0);
    tick();
    check("rd_err_pulse_end", KEY_W'(rd_err), 0);

    // Sixth pair to a full slot is rejected and must not touch the data.
    pair_valid = 1'b1; wr_slot = 1'b0; pair_data = {128'hdead, 128'hbeef};
    tick();
    pair_valid = 1'b0;
    check("wr_err_full", KEY_W'(wr_err), 1);
    tick();
    check("wr_err_pulse_end", KEY_W'(wr_err), 0);

    // Forward stream at full rate.
    key_ready = 1'b1;
    start_read(0, 1'b0, 1'b1);
    drain(0, ncyc);
    check("fwd_len", KEY_W'(ncyc), NK);

    // Reverse stream.
    start_read(0, 1'b1, 1'b1);
    drain(0, ncyc);
    check("rev_len", KEY_W'(ncyc), NK);

    // Backpressured forward stream.
    start_read(0, 1'b0, 1'b1);
    drain(1, ncyc);

    // Write traffic while slot 0 streams.
    start_read(0, 1'b0, 1'b1);
    wr_start = 1'b1; wr_slot = 1'b0;
    consume_cycle(1'b1);
    wr_start = 1'b0;
    check("wr_err_locked", KEY_W'(wr_err), 1);
    wr_start = 1'b1; wr_slot = 1'b1; rd_start = 1'b1; rd_slot = 1'b1;
    consume_cycle(1'b1);
    wr_start = 1'b0; rd_start = 1'b0;
    check("wr_err_other", KEY_W'(wr_err), 0);
    check("rd_err_in_stream", KEY_W'(rd_err), 0);
    for (int p = 0; p < NK / 2; p++) begin
      ka = KEY_W'(32'h100 + 2 * p);
      kb = KEY_W'(32'h100 + 2 * p + 1);
      model[1][2*p]   = ka;
      model[1][2*p+1] = kb;
      pair_valid = 1'b1;
      pair_data  = {ka, kb};
      consume_cycle(1'b1);
    end
    pair_valid = 1'b0;
    check("slot_valid_11", KEY_W'(slot_valid), 2'b11);
    drain(0, ncyc);
    start_read(1, 1'b1, 1'b1);
    drain(0, ncyc);

    // Reset in the middle of a stream, after four beats.
    start_read(0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) consume_cycle(1'b1);
    key_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    held_flag = 1'b0;
    check("mid_rst_valid", KEY_W'(key_valid), 0);
    check("mid_rst_busy", KEY_W'(busy), 0);
    check("mid_rst_slot_valid", KEY_W'(slot_valid), 0);
    start_read(0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
